adder_serial_param: RTL and testbench

Parametrised multi-cycle adder that replaces the fixed 4-bit combinational adder wherever wide operands must be added with a small, reusable ripple slice. It adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a start/busy/done handshake. It reports sum, unsigned carry-out and two's-complement overflow. It sits between a register-file or controller front end and any datapath that can tolerate a fixed multi-cycle latency.

---
 rtl/adder_pkg.sv | 27 ++
 rtl/adder_digit.sv | 29 ++
 rtl/adder_serial_param.sv | 133 +++++++++++++
 tb/tb_adder_serial_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_e    : FSM encoding (IDLE, RUN)
//   ndig_f     : number of DIGIT-wide steps in a WIDTH-bit addition
//   cnt_w_f    : digit counter width, $clog2(NDIG) but never below 1
//   cfg_ok_f   : legality of a WIDTH/DIGIT pair (WIDTH a multiple of DIGIT)
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int ndig_f(input int w, input int d);
    return w / d;
  endfunction

  function automatic int cnt_w_f(input int w, input int d);
    int n;
    n = w / d;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok_f(input int w, input int d);
    return (d > 0) && (w >= d) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice.
//   a_i, b_i : DIGIT-bit addends
//   cin_i    : carry in
//   sum_o    : DIGIT-bit sum
//   cout_o   : carry out of the top bit
module adder_digit
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o
);

  logic [DIGIT:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[DIGIT];

endmodule

// File: rtl/adder_serial_param.sv
// Digit-serial WIDTH-bit adder: one DIGIT-bit slice reused NDIG times.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : request, taken only while idle
//   a_i, b_i      : operands, latched on an accepted start
//   cin_i         : carry in, latched on an accepted start
//   busy_o        : operation in flight
//   done_o        : one-cycle completion pulse
//   sum_o         : result, held until the next completion
//   cout_o        : unsigned carry out of bit WIDTH-1
//   ovf_o         : two's-complement overflow
// Latency is NDIG cycles from the accepting edge; all outputs are registered.
module adder_serial_param
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int             NDIG = ndig_f(WIDTH, DIGIT);
  localparam int             CW   = cnt_w_f(WIDTH, DIGIT);
  localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

  if (!cfg_ok_f(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("adder_serial_param: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_sh_q;
  logic             carry_q;
  // Operand sign bits are kept aside because the operand registers
  // shift them away before the overflow decision is made.
  logic             a_msb_q, b_msb_q;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, sum_sh_d;
  logic             ovf_d;

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i   (a_q[DIGIT-1:0]),
    .b_i   (b_q[DIGIT-1:0]),
    .cin_i (carry_q),
    .sum_o (dig_sum),
    .cout_o(dig_cout)
  );

  // Low digit is consumed each step; the new sum digit enters at the top so
  // that after NDIG steps the LSB digit has walked down to bit 0.
  if (NDIG == 1) begin : g_single
    assign sum_sh_d = dig_sum;
    assign a_sh_d   = '0;
    assign b_sh_d   = '0;
  end else begin : g_multi
    assign sum_sh_d = {dig_sum, sum_sh_q[WIDTH-1:DIGIT]};
    assign a_sh_d   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_sh_d   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
  end

  // Only meaningful on the final step, when sum_sh_d holds the full result.
  assign ovf_d = (a_msb_q == b_msb_q) && (sum_sh_d[WIDTH-1] != a_msb_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_sh_d;
          b_q      <= b_sh_d;
          carry_q  <= dig_cout;
          sum_sh_q <= sum_sh_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_sh_d;
            cout_q  <= dig_cout;
            ovf_q   <= ovf_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_adder_serial_param.sv
// Self-checking bench for adder_serial_param. Four instances share one
// operand bus: 16/4 (directed), 16/16, 16/1 and 8/2 (random regression).
// Expected results come from a behavioural A+B+Cin model, queued when a
// request is driven and compared when the matching done pulse arrives.
module tb_adder_serial_param;

  localparam int NCFG = 4;
  localparam int NRND = 1000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     ra = '0, rb = '0;
  logic            rcin = 1'b0;
  logic [NCFG-1:0] rstart = '0;
  logic [NCFG-1:0] rbusy, rdone, rcout, rovf;
  logic [15:0]     rsum [NCFG];

  int          errors = 0;
  int          checks = 0;
  logic [17:0] sb [$];

  always #5 clk = ~clk;

  function automatic int w_of(input int g);
    case (g)
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int d_of(input int g);
    case (g)
      0:       return 4;
      1:       return 16;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = w_of(g);
    localparam int D = d_of(g);
    logic [W-1:0] s;
    adder_serial_param #(.WIDTH(W), .DIGIT(D)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .start_i(rstart[g]),
      .a_i    (ra[W-1:0]),
      .b_i    (rb[W-1:0]),
      .cin_i  (rcin),
      .busy_o (rbusy[g]),
      .done_o (rdone[g]),
      .sum_o  (s),
      .cout_o (rcout[g]),
      .ovf_o  (rovf[g])
    );
    assign rsum[g] = 16'(s);
  end

  // Returns {cout, ovf, sum} for a w-bit addition.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, b, input logic c);
    logic [16:0] s;
    logic [15:0] m, am, bm, sm;
    logic        co, ov;
    m  = (w == 16) ? 16'hFFFF : 16'((1 << w) - 1);
    am = a & m;
    bm = b & m;
    s  = {1'b0, am} + {1'b0, bm} + 17'(c);
    sm = s[15:0] & m;
    co = s[w];
    ov = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
    return {co, ov, sm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input int g);
    logic [17:0] e;
    if (sb.size() == 0) begin
      chk($sformatf("sb_underflow%0d", g), 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("sum%0d", g),  32'(rsum[g]),  32'(e[15:0]));
    chk($sformatf("cout%0d", g), 32'(rcout[g]), 32'(e[17]));
    chk($sformatf("ovf%0d", g),  32'(rovf[g]),  32'(e[16]));
  endtask

  // Called at a negedge with the instance idle or in its done cycle.
  task automatic run_op(input int g, input logic [15:0] ta, input logic [15:0] tbv, input logic tc);
    int lat, bc, nd;
    nd = w_of(g) / d_of(g);
    ra = ta; rb = tbv; rcin = tc; rstart[g] = 1'b1;
    sb.push_back(model(w_of(g), ta, tbv, tc));
    @(negedge clk);
    rstart[g] = 1'b0;
    // operands are free to change once accepted
    ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
    lat = 0; bc = 0;
    while (!rdone[g] && lat < nd + 4) begin
      if (rbusy[g]) bc++;
      @(negedge clk);
      lat++;
    end
    if (rbusy[g]) bc++;
    chk($sformatf("latency%0d", g), 32'(lat), 32'(nd));
    chk($sformatf("busy_cycles%0d", g), 32'(bc), 32'(nd));
    sb_check(g);
  endtask

  initial begin
    int lat, dn, k, gaps, cyc;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(rbusy[0]), 32'd0);
    chk("rst_done", 32'(rdone[0]), 32'd0);
    chk("rst_sum",  32'(rsum[0]),  32'd0);
    chk("rst_cout", 32'(rcout[0]), 32'd0);
    chk("rst_ovf",  32'(rovf[0]),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed values
    run_op(0, 16'd2, 16'd3, 1'b0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0);
    run_op(0, 16'h8000, 16'h8000, 1'b1);

    // start while busy is ignored
    ra = 16'd2; rb = 16'd3; rcin = 1'b0; rstart[0] = 1'b1;
    sb.push_back(model(16, 16'd2, 16'd3, 1'b0));
    @(negedge clk); rstart[0] = 1'b0;
    @(negedge clk); ra = 16'h1111; rb = 16'h1111; rstart[0] = 1'b1;
    @(negedge clk); rstart[0] = 1'b0;
    lat = 2;
    while (!rdone[0] && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_latency", 32'(lat), 32'd4);
    sb_check(0);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdone[0]) dn++;
    end
    chk("ign_extra_done", 32'(dn), 32'd0);

    // start held high: each done cycle accepts the next pair, no idle gap
    ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
    sb.push_back(model(16, ra, rb, rcin));
    rstart[0] = 1'b1;
    k = 0; gaps = 0; cyc = 0;
    while (k < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rdone[0]) begin
        sb_check(0);
        k++;
        if (k < 6) begin
          ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
          sb.push_back(model(16, ra, rb, rcin));
        end else begin
          rstart[0] = 1'b0;
        end
      end else if (!rbusy[0]) begin
        gaps++;
      end
    end
    chk("held_count", 32'(k), 32'd6);
    chk("held_gaps", 32'(gaps), 32'd0);

    // make sure outputs are non-zero before the abort
    run_op(0, 16'h1234, 16'h4321, 1'b1);

    // reset two cycles into an operation
    ra = 16'hFFFF; rb = 16'h0001; rcin = 1'b0; rstart[0] = 1'b1;
    @(negedge clk); rstart[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(rbusy[0]), 32'd0);
    chk("abort_done", 32'(rdone[0]), 32'd0);
    chk("abort_sum",  32'(rsum[0]),  32'd0);
    chk("abort_cout", 32'(rcout[0]), 32'd0);
    chk("abort_ovf",  32'(rovf[0]),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdone[0] || rbusy[0]) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    // random regression on the other widths
    for (int g = 1; g < NCFG; g++) begin
      for (int n = 0; n < NRND; n++) begin
        run_op(g, 16'($urandom), 16'($urandom), 1'($urandom));
      end
    end

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
